// File: rtl/sram_word_arbiter_pkg.sv
// Shared types and encodings for the two-port 32-bit to 16-bit SRAM word arbiter.
package sram_word_arbiter_pkg;

    localparam int unsigned DATA_W = 32;
    localparam int unsigned HALF_W = 16;

    localparam logic CMD_WRITE = 1'b0;
    localparam logic CMD_READ  = 1'b1;
    localparam logic HALF_HI   = 1'b0;
    localparam logic HALF_LO   = 1'b1;

    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_HI_ISSUE = 3'd1,
        ST_HI_WAIT  = 3'd2,
        ST_LO_ISSUE = 3'd3,
        ST_LO_WAIT  = 3'd4,
        ST_RESP     = 3'd5
    } state_e;

    // Latched request payload, held for the whole two-half transaction.
    typedef struct packed {
        logic              write;
        logic              port;
        logic [DATA_W-1:0] wdata;
    } req_lat_t;

    function automatic logic [HALF_W-1:0] half_of(input logic [DATA_W-1:0] w, input logic half);
        return (half == HALF_HI) ? w[DATA_W-1:HALF_W] : w[HALF_W-1:0];
    endfunction

endpackage

// File: rtl/sram_word_arbiter_rr_arbiter2.sv
// Two-way round-robin grant: on contention the port that did not win last time gets the grant.
module rr_arbiter2 (
    input  logic [1:0] valid_i,
    input  logic       last_grant_i,
    output logic [1:0] grant_o
);

    always_comb begin
        grant_o = 2'b00;
        if (valid_i == 2'b11) begin
            grant_o = last_grant_i ? 2'b01 : 2'b10;
        end else begin
            grant_o = valid_i;
        end
    end

endmodule

// File: rtl/sram_word_arbiter.sv
// Round-robin arbiter splitting 32-bit word requests from two ports into two 16-bit SRAM
// transactions (high half first), with a per-half watchdog and a sticky abort flag.
module sram_word_arbiter
    import sram_word_arbiter_pkg::*;
#(
    parameter int unsigned ADDR_W  = 19,
    parameter int unsigned TIMEOUT = 255
) (
    input  logic              clk,
    input  logic              reset,

    input  logic              req0_valid,
    output logic              req0_ready,
    input  logic              req0_write,
    input  logic [ADDR_W-1:0] req0_addr,
    input  logic [DATA_W-1:0] req0_wdata,
    output logic              rsp0_valid,
    output logic [DATA_W-1:0] rsp0_rdata,
    output logic              rsp0_err,

    input  logic              req1_valid,
    output logic              req1_ready,
    input  logic              req1_write,
    input  logic [ADDR_W-1:0] req1_addr,
    input  logic [DATA_W-1:0] req1_wdata,
    output logic              rsp1_valid,
    output logic [DATA_W-1:0] rsp1_rdata,
    output logic              rsp1_err,

    output logic              mem_start,
    output logic              mem_command,
    output logic [ADDR_W:0]   mem_address,
    output logic [HALF_W-1:0] mem_wdata,
    input  logic [HALF_W-1:0] mem_rdata,
    input  logic              mem_finish,

    output logic              busy,
    output logic              err_sticky
);

    localparam int unsigned TMR_W = $clog2(TIMEOUT + 1);

    state_e              state_q;
    logic                last_grant_q;
    logic [TMR_W-1:0]    timer_q;
    req_lat_t            lat_q;
    logic [ADDR_W-1:0]   addr_q;
    logic [HALF_W-1:0]   hi_q;

    logic                mem_start_q;
    logic                mem_command_q;
    logic [ADDR_W:0]     mem_address_q;
    logic [HALF_W-1:0]   mem_wdata_q;
    logic                rsp0_valid_q, rsp1_valid_q;
    logic                rsp0_err_q, rsp1_err_q;
    logic [DATA_W-1:0]   rsp0_rdata_q, rsp1_rdata_q;
    logic                busy_q;
    logic                err_q;

    logic [1:0]          grant;
    logic                accept;
    logic                sel_write;
    logic [ADDR_W-1:0]   sel_addr;
    logic [DATA_W-1:0]   sel_wdata;
    logic                timeout_c;
    logic                enter_resp_c;
    logic                resp_err_c;
    logic [DATA_W-1:0]   resp_word_c;

    rr_arbiter2 u_rr (
        .valid_i      ({req1_valid, req0_valid}),
        .last_grant_i (last_grant_q),
        .grant_o      (grant)
    );

    assign req0_ready = (state_q == ST_IDLE) & grant[0];
    assign req1_ready = (state_q == ST_IDLE) & grant[1];
    assign accept     = (req0_valid & req0_ready) | (req1_valid & req1_ready);
    assign timeout_c  = (timer_q == TMR_W'(TIMEOUT - 1));

    // Payload of whichever port the arbiter is currently granting.
    always_comb begin
        sel_write = req0_write;
        sel_addr  = req0_addr;
        sel_wdata = req0_wdata;
        if (grant[1]) begin
            sel_write = req1_write;
            sel_addr  = req1_addr;
            sel_wdata = req1_wdata;
        end
    end

    // Response launch: low-half finish or watchdog expiry in either wait state.
    always_comb begin
        enter_resp_c = 1'b0;
        resp_err_c   = 1'b0;
        resp_word_c  = {hi_q, HALF_W'(0)};
        if (state_q == ST_HI_WAIT) begin
            if (!mem_finish && timeout_c) begin
                enter_resp_c = 1'b1;
                resp_err_c   = 1'b1;
            end
        end else if (state_q == ST_LO_WAIT) begin
            if (mem_finish) begin
                enter_resp_c = 1'b1;
                resp_word_c  = {hi_q, mem_rdata};
            end else if (timeout_c) begin
                enter_resp_c = 1'b1;
                resp_err_c   = 1'b1;
            end
        end
        if (lat_q.write) begin
            resp_word_c = '0;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q       <= ST_IDLE;
            last_grant_q  <= 1'b1;
            timer_q       <= '0;
            lat_q         <= '0;
            addr_q        <= '0;
            hi_q          <= '0;
            mem_start_q   <= 1'b0;
            mem_command_q <= 1'b0;
            mem_address_q <= '0;
            mem_wdata_q   <= '0;
            rsp0_valid_q  <= 1'b0;
            rsp1_valid_q  <= 1'b0;
            rsp0_err_q    <= 1'b0;
            rsp1_err_q    <= 1'b0;
            rsp0_rdata_q  <= '0;
            rsp1_rdata_q  <= '0;
            busy_q        <= 1'b0;
            err_q         <= 1'b0;
        end else begin
            mem_start_q  <= 1'b0;
            rsp0_valid_q <= 1'b0;
            rsp1_valid_q <= 1'b0;

            case (state_q)
                ST_IDLE: begin
                    if (accept) begin
                        lat_q         <= '{write: sel_write, port: grant[1], wdata: sel_wdata};
                        addr_q        <= sel_addr;
                        hi_q          <= '0;
                        last_grant_q  <= grant[1];
                        mem_start_q   <= 1'b1;
                        mem_command_q <= sel_write ? CMD_WRITE : CMD_READ;
                        mem_address_q <= {sel_addr, HALF_HI};
                        mem_wdata_q   <= half_of(sel_wdata, HALF_HI);
                        busy_q        <= 1'b1;
                        state_q       <= ST_HI_ISSUE;
                    end
                end
                ST_HI_ISSUE: begin
                    timer_q <= '0;
                    state_q <= ST_HI_WAIT;
                end
                ST_HI_WAIT: begin
                    if (mem_finish) begin
                        hi_q          <= mem_rdata;
                        mem_start_q   <= 1'b1;
                        mem_address_q <= {addr_q, HALF_LO};
                        mem_wdata_q   <= half_of(lat_q.wdata, HALF_LO);
                        state_q       <= ST_LO_ISSUE;
                    end else if (!timeout_c) begin
                        timer_q <= timer_q + TMR_W'(1);
                    end
                end
                ST_LO_ISSUE: begin
                    timer_q <= '0;
                    state_q <= ST_LO_WAIT;
                end
                ST_LO_WAIT: begin
                    if (!mem_finish && !timeout_c) begin
                        timer_q <= timer_q + TMR_W'(1);
                    end
                end
                ST_RESP: begin
                    busy_q  <= 1'b0;
                    state_q <= ST_IDLE;
                end
                default: begin
                    busy_q  <= 1'b0;
                    state_q <= ST_IDLE;
                end
            endcase

            if (enter_resp_c) begin
                state_q <= ST_RESP;
                err_q   <= err_q | resp_err_c;
                if (lat_q.port) begin
                    rsp1_valid_q <= 1'b1;
                    rsp1_rdata_q <= resp_word_c;
                    rsp1_err_q   <= resp_err_c;
                end else begin
                    rsp0_valid_q <= 1'b1;
                    rsp0_rdata_q <= resp_word_c;
                    rsp0_err_q   <= resp_err_c;
                end
            end
        end
    end

    assign mem_start   = mem_start_q;
    assign mem_command = mem_command_q;
    assign mem_address = mem_address_q;
    assign mem_wdata   = mem_wdata_q;
    assign rsp0_valid  = rsp0_valid_q;
    assign rsp0_rdata  = rsp0_rdata_q;
    assign rsp0_err    = rsp0_err_q;
    assign rsp1_valid  = rsp1_valid_q;
    assign rsp1_rdata  = rsp1_rdata_q;
    assign rsp1_err    = rsp1_err_q;
    assign busy        = busy_q;
    assign err_sticky  = err_q;

endmodule
